// File: rtl/adc_serial_pkg.sv
// Shared constants and state type for the serial ADC link.
// Used by the responder and the controller's ADC reader.
package adc_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE
  } adc_state_e;

  localparam int ADC_DATA_WIDTH  = 8;
  localparam int ADC_NULL_CLKS   = 1;
  localparam int ADC_SYNC_STAGES = 2;

  function automatic int adc_cnt_width(
    input int dw,
    input int nc
  );
    return $clog2(((dw > nc) ? dw : nc) + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser chain plus history flop giving level and edges.
// Ports: i_clk, i_reset, i_async in; o_level, o_rise, o_fall out.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // Reset to the idle-high level so no edge is seen at start-up.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '1;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = ~r_hist & o_level;
  assign o_fall  = r_hist & ~o_level;

endmodule

// File: rtl/adc_serial_responder.sv
// Emulates an 8-bit serial ADC: latch on cs_n fall, shift MSB first.
// Ports: i_clk, i_reset, i_sample_in, i_adc_clk_in, i_cs_n_in in;
//        o_data_out, o_data_oe, o_busy, o_conv_done, o_conv_abort out.
module adc_serial_responder
  import adc_serial_pkg::*;
#(
  parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
  parameter int NULL_CLKS   = ADC_NULL_CLKS,
  parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_sample_in,
  input  logic                  i_adc_clk_in,
  input  logic                  i_cs_n_in,
  output logic                  o_data_out,
  output logic                  o_data_oe,
  output logic                  o_busy,
  output logic                  o_conv_done,
  output logic                  o_conv_abort
);

  localparam int CW =
    adc_cnt_width(DATA_WIDTH, NULL_CLKS);
  localparam logic [CW-1:0] C_NULL_LAST =
    CW'(NULL_CLKS - 1);
  localparam logic [CW-1:0] C_LAST =
    CW'(DATA_WIDTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic w_clk_level, w_clk_rise, w_clk_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_unused;

  adc_state_e            r_state, w_state;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  r_dout, w_dout;
  logic                  r_done, w_done;
  logic                  r_abort, w_abort;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_adc_clk_in),
    .o_level (w_clk_level),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_cs_n_in),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // The controller samples on adc_clk rise; only falls matter here.
  assign w_unused = ^{w_clk_level, w_clk_rise, w_cs_level};

  always_comb begin
    w_state = r_state;
    w_shreg = r_shreg;
    w_cnt   = r_cnt;
    w_dout  = r_dout;
    w_done  = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_dout = 1'b0;
        if (w_cs_fall) begin
          w_shreg = i_sample_in;
          w_cnt   = '0;
          w_state = ST_SETUP;
        end
      end
      ST_SETUP, ST_SHIFT: begin
        // cs_n rise beats a simultaneous adc_clk fall.
        if (w_cs_rise) begin
          w_dout  = 1'b0;
          w_abort = 1'b1;
          w_state = ST_IDLE;
        end else if (w_clk_fall) begin
          if (r_state == ST_SETUP &&
              r_cnt != C_NULL_LAST) begin
            w_cnt = r_cnt + C_ONE;
          end else if (r_state == ST_SETUP ||
                       r_cnt < C_LAST) begin
            // Shift left so the next bit is always at MSB.
            w_dout  = r_shreg[DATA_WIDTH-1];
            w_shreg = {r_shreg[DATA_WIDTH-2:0], 1'b0};
            w_cnt   = (r_state == ST_SETUP) ?
                      C_ONE : r_cnt + C_ONE;
            w_state = ST_SHIFT;
          end else begin
            w_dout  = 1'b0;
            w_done  = 1'b1;
            w_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_dout = 1'b0;
        if (w_cs_rise) begin
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shreg <= w_shreg;
      r_cnt   <= w_cnt;
      r_dout  <= w_dout;
      r_done  <= w_done;
      r_abort <= w_abort;
    end
  end

  assign o_data_out   = r_dout;
  assign o_data_oe    = (r_state != ST_IDLE);
  assign o_busy       = (r_state == ST_SETUP) ||
                        (r_state == ST_SHIFT);
  assign o_conv_done  = r_done;
  assign o_conv_abort = r_abort;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder acting as the controller side.
// Scoreboard queue of expected bytes; all checks via chk().
module tb_adc_serial_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_clk;
  logic       cs_n;
  logic [7:0] sample;

  logic d1, oe1, busy1, done1, abort1;
  logic d2, oe2, busy2, done2, abort2;

  int n_chk   = 0;
  int n_err   = 0;
  int n_done  = 0;
  int n_abort = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  adc_serial_responder dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_sample_in  (sample),
    .i_adc_clk_in (adc_clk),
    .i_cs_n_in    (cs_n),
    .o_data_out   (d1),
    .o_data_oe    (oe1),
    .o_busy       (busy1),
    .o_conv_done  (done1),
    .o_conv_abort (abort1)
  );

  adc_serial_responder #(.NULL_CLKS(2)) dut2 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_sample_in  (sample),
    .i_adc_clk_in (adc_clk),
    .i_cs_n_in    (cs_n),
    .o_data_out   (d2),
    .o_data_oe    (oe2),
    .o_busy       (busy2),
    .o_conv_done  (done2),
    .o_conv_abort (abort2)
  );

  always @(posedge clk) begin
    if (done1)  n_done++;
    if (abort1) n_abort++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full 10-period conversion; reads 8 bits after the null phase.
  task automatic conv(
    input  logic [7:0] s,
    input  logic [7:0] s_mid,
    input  bit         sel2,
    output logic [7:0] rd
  );
    int first;
    first  = sel2 ? 3 : 2;
    rd     = '0;
    sample = s;
    cs_n   = 1'b0;
    cyc(8);
    for (int p = 1; p <= 10; p++) begin
      if (p >= first && p < first + 8)
        rd = {rd[6:0], sel2 ? d2 : d1};
      adc_clk = 1'b1;
      cyc(8);
      adc_clk = 1'b0;
      if (p == 4) sample = s_mid;
      cyc(8);
    end
  endtask

  task automatic partial(input logic [7:0] s);
    sample = s;
    cs_n   = 1'b0;
    cyc(8);
    for (int p = 1; p <= 4; p++) begin
      adc_clk = 1'b1;
      cyc(8);
      adc_clk = 1'b0;
      cyc(8);
    end
  endtask

  task automatic cs_release();
    cs_n = 1'b1;
    cyc(4);
  endtask

  initial begin
    logic [7:0] rd;
    int d0, a0;
    rst     = 1'b1;
    adc_clk = 1'b0;
    cs_n    = 1'b1;
    sample  = '0;
    cyc(3);
    chk("rst_oe",    oe1,    0);
    chk("rst_busy",  busy1,  0);
    chk("rst_dout",  d1,     0);
    chk("rst_done",  done1,  0);
    chk("rst_abort", abort1, 0);
    rst = 1'b0;
    cyc(4);

    exp_q.push_back(8'hA5);
    d0 = n_done;
    conv(8'hA5, 8'hA5, 1'b0, rd);
    chk("a5_read", rd, exp_q.pop_front());
    chk("a5_done", n_done - d0, 1);
    chk("a5_busy", busy1, 0);
    chk("a5_oe_done", oe1, 1);
    cs_release();
    chk("a5_oe_idle", oe1, 0);

    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    conv(8'h00, 8'h00, 1'b0, rd);
    chk("b2b_00", rd, exp_q.pop_front());
    cs_release();
    chk("b2b_oe_idle", oe1, 0);
    conv(8'hFF, 8'hFF, 1'b0, rd);
    chk("b2b_ff", rd, exp_q.pop_front());
    cs_release();

    d0 = n_done;
    a0 = n_abort;
    partial(8'hE7);
    cs_n = 1'b1;
    cyc(4);
    chk("abt_oe",    oe1, 0);
    chk("abt_busy",  busy1, 0);
    chk("abt_pulse", n_abort - a0, 1);
    chk("abt_nodone", n_done - d0, 0);
    cyc(4);
    exp_q.push_back(8'h3C);
    conv(8'h3C, 8'h3C, 1'b0, rd);
    chk("abt_3c", rd, exp_q.pop_front());
    cs_release();

    exp_q.push_back(8'h5A);
    conv(8'h5A, 8'hC3, 1'b0, rd);
    chk("mid_5a", rd, exp_q.pop_front());
    cs_release();

    d0 = n_done;
    a0 = n_abort;
    partial(8'h7E);
    chk("rst_pre_busy", busy1, 1);
    rst  = 1'b1;
    cs_n = 1'b1;
    cyc(1);
    chk("rst_mid_oe",   oe1, 0);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_dout", d1, 0);
    cyc(2);
    rst = 1'b0;
    cyc(4);
    chk("rst_no_done",  n_done - d0, 0);
    chk("rst_no_abort", n_abort - a0, 0);
    exp_q.push_back(8'h81);
    conv(8'h81, 8'h81, 1'b0, rd);
    chk("rst_81", rd, exp_q.pop_front());
    cs_release();

    exp_q.push_back(8'h96);
    conv(8'h96, 8'h96, 1'b1, rd);
    chk("null2_96", rd, exp_q.pop_front());
    chk("null2_busy", busy2, 0);
    cs_release();
    chk("null2_oe", oe2, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
